// File: rtl/zy_cpu_pkg.sv
// Shared CPU definitions: machine width, instruction memory geometry and the
// fetch buffer entry layout.
package zy_cpu_pkg;

    localparam int          XLEN     = 32;
    localparam int          IMEM_AW  = 10;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the PC it was read from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential word PC; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries. Flush beats push; the caller
// guarantees no push into a full buffer and no pop from an empty one.
module fetch_buf
    import zy_cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  fetch_entry_t   push_data,
    input  logic           pop,
    input  logic           flush,
    output logic [CW-1:0]  count,
    output fetch_entry_t   head
);

    fetch_entry_t   mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Entry storage; contents are qualified by count so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one word address per cycle to a 1-cycle synchronous
// instruction memory, buffers returning words with their PC and hands them to
// decode over valid/ready. Redirects flush all wrong-path words.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = zy_cpu_pkg::RESET_PC,
    parameter int          BUF_DEPTH = 2,
    parameter int          IMEM_AW   = zy_cpu_pkg::IMEM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_redirect,
    input  logic [31:0]        i_redirect_pc,
    input  logic               i_halt,
    output logic [IMEM_AW-1:0] o_imem_addr,
    input  logic [31:0]        i_imem_dout,
    output logic               o_valid,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_instr,
    input  logic               i_ready
);
    import zy_cpu_pkg::*;

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   fetch_pc_r;
    logic          req_v_r;
    logic [31:0]   req_pc_r;

    logic [31:0]   issue_pc_s;
    logic          valid_s;
    logic          deq_s;
    logic          credit_ok_s;
    logic          issue_s;
    logic          push_s;
    logic [CW-1:0] count_s;
    fetch_entry_t  push_data_s;
    fetch_entry_t  head_s;

    // Issue decision: a redirect always issues (the buffer is being flushed),
    // otherwise only while buffered + in-flight - leaving stays below depth.
    always_comb begin
        issue_pc_s  = i_redirect ? (i_redirect_pc & 32'hFFFF_FFFC) : fetch_pc_r;
        valid_s     = !rst && (count_s != {CW{1'b0}});
        deq_s       = valid_s && i_ready;
        credit_ok_s = i_redirect ||
                      ((int'(count_s) + int'(req_v_r)) < (BUF_DEPTH + int'(deq_s)));
        issue_s     = !rst && !i_halt && credit_ok_s;
        push_s      = req_v_r && !i_redirect;
        push_data_s.pc    = req_pc_r;
        push_data_s.instr = i_imem_dout;
    end

    // PC and in-flight request tracking; a non-issuing cycle still latches a
    // redirect target because issue_pc_s already selects it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            req_v_r    <= 1'b0;
            req_pc_r   <= 32'h0000_0000;
        end else if (issue_s) begin
            fetch_pc_r <= next_word_pc(issue_pc_s);
            req_v_r    <= 1'b1;
            req_pc_r   <= issue_pc_s;
        end else begin
            fetch_pc_r <= issue_pc_s;
            req_v_r    <= 1'b0;
            req_pc_r   <= req_pc_r;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (deq_s),
        .flush     (i_redirect),
        .count     (count_s),
        .head      (head_s)
    );

    assign o_imem_addr = issue_pc_s[IMEM_AW+1:2];
    assign o_valid     = valid_s;
    assign o_pc        = valid_s ? head_s.pc    : 32'h0000_0000;
    assign o_instr     = valid_s ? head_s.instr : 32'h0000_0000;

endmodule
